ph_hostread_ctl: RTL

- Host-side read sequencer; sits directly downstream of the four-register parasite-to-host FIFO group.
- Decodes host register accesses into a one-hot register select plus a single-cycle pop strobe.
- Captures the popped byte and returns it to the host bus with fixed latency.
- Also formats per-register status bytes and holds the host control/interrupt-enable register.

---
 rtl/tube_pkg.sv | 29 ++
 rtl/ph_ctrl_reg.sv | 52 +++++
 rtl/ph_hostread_ctl.sv | 87 ++++++++
 3 files changed

// File: rtl/tube_pkg.sv
// Shared types and constants for the host-side read path of the parasite-to-host FIFO group.
package tube_pkg;

    localparam int NREG          = 4;
    localparam int STAT_LOW_BITS = 6;

    localparam logic [2:0] CTRL_ADDR = 3'b000;
    localparam int         DATA_BIT  = 0;

    localparam int STAT_AVAIL = 7;
    localparam int STAT_NFULL = 6;

    typedef enum logic [1:0] {
        IDLE,
        SEL,
        RESP
    } state_t;

    typedef struct packed {
        logic [1:0] idx;
        logic       is_data;
    } req_t;

    function automatic logic [NREG-1:0] onehot(input logic [1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/ph_ctrl_reg.sv
// Host control register with set/clear writes and the optional interrupt.
// Interrupt generation is enabled by defining PH_HOSTREAD_IRQ_EN.
module ph_ctrl_reg
    import tube_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wdata,
    input  logic                     irq_src,
    output logic [STAT_LOW_BITS-1:0] ctrl,
    output logic                     irq
);

    logic [STAT_LOW_BITS-1:0] ctrl_nxt;
    logic                     wdata_unused;

    assign wdata_unused = wdata[6];

    // Bit 7 picks set or clear; the low bits select which flags are touched.
    always_comb begin
        ctrl_nxt = ctrl;
        if (wr_en) begin
            if (wdata[7])
                ctrl_nxt = ctrl | wdata[STAT_LOW_BITS-1:0];
            else
                ctrl_nxt = ctrl & ~wdata[STAT_LOW_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ctrl <= '0;
        else
            ctrl <= ctrl_nxt;
    end

`ifdef PH_HOSTREAD_IRQ_EN
    // Using the next ctrl value lets a clearing write drop the irq on the same edge.
    always_ff @(posedge clk) begin
        if (rst)
            irq <= 1'b0;
        else
            irq <= ctrl_nxt[0] & irq_src;
    end
`else
    logic irq_src_unused;
    assign irq_src_unused = irq_src;
    assign irq            = 1'b0;
`endif

endmodule

// File: rtl/ph_hostread_ctl.sv
// Host read sequencer: decodes host reads into select/pop, returns data or status two edges later.
// Optional interrupt output is enabled by defining PH_HOSTREAD_IRQ_EN.
module ph_hostread_ctl
    import tube_pkg::*;
(
    input  logic            h_phi2,
    input  logic            h_rst,
    input  logic            h_cs,
    input  logic            h_rdnw,
    input  logic [2:0]      h_addr,
    input  logic [7:0]      h_din,
    input  logic [7:0]      ph_data,
    input  logic [NREG-1:0] ph_avail,
    input  logic [NREG-1:0] hp_full,
    output logic [NREG-1:0] ph_select,
    output logic            ph_rd,
    output logic [7:0]      h_dout,
    output logic            h_dout_valid,
    output logic            h_busy,
    output logic            h_irq
);

    state_t                   state;
    req_t                     req;
    logic [STAT_LOW_BITS-1:0] ctrl;
    logic                     ctrl_wr;
    logic [7:0]               status_byte;

    assign ctrl_wr = (state == IDLE) && h_cs && !h_rdnw && (h_addr == CTRL_ADDR);
    assign h_busy  = (state != IDLE);

    // Live ph_avail gates the pop so an empty register is never popped.
    assign ph_rd = (state == SEL) && req.is_data && ph_avail[req.idx];

    always_comb begin
        status_byte                      = '0;
        status_byte[STAT_AVAIL]          = ph_avail[req.idx];
        status_byte[STAT_NFULL]          = ~hp_full[req.idx];
        status_byte[STAT_LOW_BITS-1:0]   = ctrl;
    end

    always_ff @(posedge h_phi2) begin
        if (h_rst) begin
            state        <= IDLE;
            req          <= '0;
            ph_select    <= '0;
            h_dout       <= '0;
            h_dout_valid <= 1'b0;
        end else begin
            h_dout_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (h_cs && h_rdnw) begin
                        req       <= '{idx: h_addr[2:1], is_data: h_addr[DATA_BIT]};
                        ph_select <= onehot(h_addr[2:1]);
                        state     <= SEL;
                    end
                end
                SEL: begin
                    state <= RESP;
                end
                RESP: begin
                    // ph_select is still held here, so ph_data reflects the selected register.
                    h_dout       <= req.is_data ? ph_data : status_byte;
                    h_dout_valid <= 1'b1;
                    ph_select    <= '0;
                    state        <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    ph_select <= '0;
                end
            endcase
        end
    end

    ph_ctrl_reg u_ctrl (
        .clk     (h_phi2),
        .rst     (h_rst),
        .wr_en   (ctrl_wr),
        .wdata   (h_din),
        .irq_src (ph_avail[NREG-1]),
        .ctrl    (ctrl),
        .irq     (h_irq)
    );

endmodule
